// File: rtl/avalon_dual_ram_arb_if.sv
// ---------------------------------------------------------------------------
// avalon_dual_ram_arb_if
// One Avalon-MM slave port of avalon_dual_ram_arb.
//   address        word address
//   chipselect     port select
//   read / write   request strobes (both high is treated as a write)
//   byteenable     byte-lane enables for writes
//   writedata      write data
//   readdata       read data, holds its last value between strobes
//   readdatavalid  one-cycle read-data strobe
//   waitrequest    request not accepted this cycle
// ---------------------------------------------------------------------------
interface avalon_dual_ram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_dual_ram_arb.sv
// ---------------------------------------------------------------------------
// avalon_dual_ram_arb
// Data memory shared by two Avalon-MM slave ports through one single-port RAM.
// Round-robin arbitration on contention, pipelined read responses with a
// latency of 1 or 2 enabled cycles, out-of-range protection, and an optional
// zero-fill of every word after reset.
//   clk        single clock
//   reset_n    asynchronous active-low reset
//   clken      global clock enable; low freezes the whole block
//   init_done  high once the block accepts traffic
//   s1, s2     Avalon-MM slave ports (s1 = CPU, s2 = DMA/accelerator)
// ---------------------------------------------------------------------------
module avalon_dual_ram_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int DEPTH          = 342,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  output logic                 init_done,
  avalon_dual_ram_arb_if.slave s1,
  avalon_dual_ram_arb_if.slave s2
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [CW-1:0] clr_cnt;
  logic          rr;        // round-robin pointer: 0 = s1 wins next contention

  logic                  req1, req2, grant1, grant2, acc1, acc2;
  logic                  do_wr, do_rd, in_range;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [CW-1:0]         idx;

  // Request decode and grant. At most one port is accepted per enabled RUN
  // cycle; the accepted port steers the single RAM address/data path.
  // NOTE: every always_comb output is assigned on every path, so no latches.
  always_comb begin
    req1   = s1.chipselect & (s1.read | s1.write);
    req2   = s2.chipselect & (s2.read | s2.write);
    grant1 = req1 & (~req2 | ~rr);
    grant2 = req2 & (~req1 | rr);
    acc1   = grant1 & clken & (state == RUN);
    acc2   = grant2 & clken & (state == RUN);
    addr   = acc2 ? s2.address    : s1.address;
    be     = acc2 ? s2.byteenable : s1.byteenable;
    wdata  = acc2 ? s2.writedata  : s1.writedata;
    // read+write together counts as a write and produces no read response
    do_wr  = (acc1 & s1.write) | (acc2 & s2.write);
    do_rd  = (acc1 & ~s1.write) | (acc2 & ~s2.write);
  end

  assign in_range = 32'(addr) < DEPTH;
  assign idx      = addr[CW-1:0];

  assign s1.waitrequest = req1 & ((state == CLEAR) | ~clken | ~grant1);
  assign s2.waitrequest = req2 & ((state == CLEAR) | ~clken | ~grant2);

  // Storage and its registered read port. Out-of-range reads load zero so no
  // address ever aliases onto an implemented word.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  // NOTE: the RAM array and its output register are deliberately not reset;
  // contents survive reset_n and are only zeroed by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state == CLEAR) begin
        if (CLEAR_ON_RESET != 0) mem[clr_cnt] <= '0;
      end else if (do_wr && in_range) begin
        for (int k = 0; k < NB; k++) begin
          if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      if (do_rd) ram_q <= in_range ? mem[idx] : '0;
    end
  end

  // Control: FSM, arbitration pointer, first response stage and per-port
  // readdata hold registers. Everything freezes while clken is low.
  logic                  v1, p1;          // stage-1 valid / port (1 = s2)
  logic                  out_v, out_p;
  logic [DATA_WIDTH-1:0] out_d, hold1, hold2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rr        <= 1'b0;
      v1        <= 1'b0;
      p1        <= 1'b0;
      hold1     <= '0;
      hold2     <= '0;
    end else if (clken) begin
      if (state == CLEAR) begin
        if (CLEAR_ON_RESET == 0 || clr_cnt == CW'(DEPTH - 1)) begin
          state     <= RUN;
          init_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end else if (req1 && req2) begin
        rr <= ~rr;                        // moves only on a contended grant
      end
      v1 <= do_rd;
      p1 <= acc2;
      if (out_v && !out_p) hold1 <= out_d;
      if (out_v &&  out_p) hold2 <= out_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2, p2;
      logic [DATA_WIDTH-1:0] q2;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          p2 <= 1'b0;
          q2 <= '0;
        end else if (clken) begin
          v2 <= v1;
          p2 <= p1;
          q2 <= ram_q;
        end
      end
      assign out_v = v2;
      assign out_p = p2;
      assign out_d = q2;
    end else begin : g_lat1
      assign out_v = v1;
      assign out_p = p1;
      assign out_d = ram_q;
    end
  endgenerate

  // A pending response is masked during a stall and shows on the first
  // enabled cycle; between strobes readdata shows the last delivered word.
  logic rdv1, rdv2;
  assign rdv1 = out_v & ~out_p & clken;
  assign rdv2 = out_v &  out_p & clken;

  assign s1.readdatavalid = rdv1;
  assign s2.readdatavalid = rdv2;
  assign s1.readdata      = rdv1 ? out_d : hold1;
  assign s2.readdata      = rdv2 ? out_d : hold2;
endmodule
